// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: entry record,
// register-index width helper and the hard-wired zero register index.
package hazard_scoreboard_pkg;

   localparam int REG_AW_MAX = 8;
   localparam int AGE_W      = 8;
   localparam int X0_IDX     = 0;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
      logic                  we;
      logic [AGE_W-1:0]      ready_age;
   } sb_entry_t;

   function automatic int reg_aw(input int nregs);
      return (nregs > 2) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority search of one source operand against the in-flight
// scoreboard entries; reports a ready forward or a not-yet-ready hazard.
module hazard_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int FWD_DEPTH = 3,
   parameter int REG_AW    = 5
) (
   input  logic [REG_AW-1:0]               rs,
   input  logic                            rs_used,
   input  sb_entry_t [FWD_DEPTH-1:0]       entries,
   input  logic [FWD_DEPTH-1:0][XLEN-1:0]  stage_data,
   output logic                            hit,
   output logic                            busy,
   output logic [XLEN-1:0]                 data
);

   logic            use_s;
   logic            match_s;
   logic            found_s;
   logic            ready_s;
   logic [XLEN-1:0] data_s;

   // Scan oldest to youngest so the youngest match overwrites any older one.
   always_comb begin
      use_s   = rs_used & (rs != REG_AW'(X0_IDX));
      match_s = 1'b0;
      found_s = 1'b0;
      ready_s = 1'b0;
      data_s  = '0;
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
         match_s = use_s & entries[i].valid & entries[i].we &
                   (entries[i].rd == REG_AW_MAX'(rs));
         found_s = found_s | match_s;
         ready_s = match_s ? (AGE_W'(i) >= entries[i].ready_age) : ready_s;
         data_s  = match_s ? stage_data[i] : data_s;
      end
      hit  = found_s & ready_s;
      busy = found_s & ~ready_s;
      data = (found_s & ready_s) ? data_s : '0;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations, forwards ready
// results to decode and stalls on unready ones. Optional HAZARD_STATS_EN
// adds saturating stall/forward activity counters.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int NUM_SRC   = 2,
   parameter int FWD_DEPTH = 3,
   parameter int LOAD_LAT  = 1,
   localparam int REG_AW   = reg_aw(NREGS)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            id_valid,
   input  logic [NUM_SRC-1:0][REG_AW-1:0]  id_rs,
   input  logic [NUM_SRC-1:0]              id_rs_used,
   input  logic [REG_AW-1:0]               id_rd,
   input  logic                            id_rd_we,
   input  logic                            id_is_load,
   input  logic                            flush,
   input  logic [FWD_DEPTH-1:0][XLEN-1:0]  stage_data,
`ifdef HAZARD_STATS_EN
   output logic [31:0]                     stall_cycles,
   output logic [31:0]                     fwd_count,
`endif
   output logic                            stall,
   output logic [NUM_SRC-1:0]              fwd_hit,
   output logic [NUM_SRC-1:0][XLEN-1:0]    fwd_data
);

   sb_entry_t [FWD_DEPTH-1:0]       entries_r;
   sb_entry_t                       new_s;
   logic [NUM_SRC-1:0]              hit_s;
   logic [NUM_SRC-1:0]              busy_s;
   logic [NUM_SRC-1:0][XLEN-1:0]    data_s;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      hazard_match #(
         .XLEN      (XLEN),
         .FWD_DEPTH (FWD_DEPTH),
         .REG_AW    (REG_AW)
      ) u_match (
         .rs         (id_rs[s]),
         .rs_used    (id_rs_used[s]),
         .entries    (entries_r),
         .stage_data (stage_data),
         .hit        (hit_s[s]),
         .busy       (busy_s[s]),
         .data       (data_s[s])
      );
   end

   // Decode-side outputs; flush kills the stall, an empty slot kills everything.
   always_comb begin
      stall = id_valid & ~flush & (|busy_s);
      for (int s = 0; s < NUM_SRC; s++) begin
         fwd_hit[s]  = id_valid & hit_s[s];
         fwd_data[s] = (id_valid & hit_s[s]) ? data_s[s] : '0;
      end
   end

   // Entry entering stage 0; x0 writes are dropped here so they never match.
   always_comb begin
      new_s.valid     = id_valid & ~stall & ~flush;
      new_s.rd        = REG_AW_MAX'(id_rd);
      new_s.we        = id_rd_we & (id_rd != REG_AW'(X0_IDX));
      new_s.ready_age = id_is_load ? AGE_W'(LOAD_LAT) : '0;
   end

   // Shift register of in-flight entries, youngest at index 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entries_r <= '0;
      end else begin
         entries_r[0] <= new_s;
         for (int i = 1; i < FWD_DEPTH; i++) begin
            entries_r[i] <= entries_r[i-1];
         end
      end
   end

`ifdef HAZARD_STATS_EN
   // Saturating activity counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= 32'd0;
         fwd_count    <= 32'd0;
      end else begin
         if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end else begin
            stall_cycles <= stall_cycles;
         end
         if ((|fwd_hit) && (fwd_count != 32'hFFFF_FFFF)) begin
            fwd_count <= fwd_count + 32'd1;
         end else begin
            fwd_count <= fwd_count;
         end
      end
   end
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NREGS, default 32, architectural registers; REG_AW = clog2(NREGS).
REQ-003 Parameter NUM_SRC, default 2, source-operand channels checked per decoded instruction.
REQ-004 Parameter FWD_DEPTH, default 3, tracked in-flight stages after decode (stage 0 = EX, youngest).
REQ-005 Parameter LOAD_LAT, default 1, stages a load result lags the stage it enters, range 0..FWD_DEPTH-1.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 id_valid  in  1  decode slot holds a real instruction.
REQ-009 id_rs  in  NUM_SRC x REG_AW  source register indices.
REQ-010 id_rs_used  in  NUM_SRC  per-source "operand actually read".
REQ-011 id_rd, id_rd_we, id_is_load  in  REG_AW, 1, 1  destination, writes-register, is-load.
REQ-012 flush  in  1  branch/jump redirect; kills decode slot and stage 0.
REQ-013 stage_data  in  FWD_DEPTH x XLEN  result value currently held by each tracked stage.
REQ-014 stall  out  1  hold PC and IF/ID this cycle.
REQ-015 fwd_hit  out  NUM_SRC  operand supplied by forwarding.
REQ-016 fwd_data  out  NUM_SRC x XLEN  forwarded value, valid when fwd_hit set.

Function
REQ-017 Scoreboard SHALL hold FWD_DEPTH entries {valid, rd, we, ready_age}; every cycle entries shift one stage older, oldest drops out.
REQ-018 Stage 0 SHALL load the decode instruction when id_valid && !stall && !flush, else a bubble (valid=0).
REQ-019 Entry result SHALL be ready at stage index >= LOAD_LAT for loads, at every stage for non-loads.
REQ-020 Per source s, a match SHALL require id_rs_used[s], id_rs[s]!=0, entry valid, we, rd==id_rs[s]; only the youngest matching entry counts.
REQ-021 Youngest match ready -> fwd_hit[s]=1, fwd_data[s]=stage_data[that stage], combinationally same cycle.
REQ-022 Youngest match not ready -> stall=1; no older entry may be used instead.
REQ-023 No match -> fwd_hit[s]=0, fwd_data[s]=0.
REQ-024 stall SHALL be the OR over sources; a stalled instruction re-evaluates each cycle, stall latency per load-use = LOAD_LAT minus distance to producer, minimum 0.
REQ-025 flush SHALL override stall: stall=0, stage 0 gets bubble, older entries keep shifting (already committed path).
REQ-026 Writes to x0 SHALL never create a match.
REQ-027 id_valid=0 SHALL force stall=0 and all fwd_hit=0.

Reset
REQ-028 reset_n low SHALL asynchronously clear all entry valid bits; stall, fwd_hit, fwd_data SHALL read 0 while reset asserted.
REQ-029 Reset mid-stall SHALL drop the stall immediately; first post-reset cycle sees an empty scoreboard.

Configuration
REQ-030 Macro HAZARD_STATS_EN: when defined, adds outputs stall_cycles (32) and fwd_count (32), saturating counters of stall cycles and cycles with any fwd_hit, cleared by reset; when undefined, outputs and counters absent, all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold the scoreboard entry struct typedef, REG_AW derivation and the x0 index constant.
REQ-032 One sub-module, hazard_match, SHALL implement per-source youngest-match priority search; instantiated NUM_SRC times.

Verification
REQ-033 ADD x5 issued, next ADD reads x5 -> fwd_hit[0]=1, fwd_data[0]=stage_data[0], stall=0.
REQ-034 LW x6 (LOAD_LAT=1), next instr reads x6 -> stall=1 one cycle, then fwd_hit=1 from stage 1.
REQ-035 x7 written by stages 0 and 2, reader of x7 -> data from stage 0 only.
REQ-036 Load-use stall with flush asserted same cycle -> stall=0, stage 0 bubble, no forward next cycle.
REQ-037 Instr writing x0 followed by reader of x0 -> fwd_hit=0, stall=0.
REQ-038 reset_n pulsed low during a load-use stall -> stall=0 immediately; HAZARD_STATS_EN counters read 0.
